// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, data width, default bit period and frame lengths.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int unsigned UART_DATA_BITS            = 8;
  localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 5208;
  localparam int unsigned UART_FRAME_BITS_NOPAR     = 10;
  localparam int unsigned UART_FRAME_BITS_PAR       = 11;

endpackage

// File: rtl/uart_baud_cnt.sv
// Per-bit cycle counter; bit_end marks the last cycle of each serial bit period.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic bit_end
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign bit_end = run && (cnt_q == CNT_LAST);

  // Held at zero while idle so every bit period starts aligned to the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!run || bit_end) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8 data bits LSB first, one stop bit.
// Define UART_TX_PARITY_EN to insert an even parity bit before the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       wr_en,
  output logic       TXD,
  output logic       busy,
  output logic       done
);

  localparam int unsigned BIT_IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [BIT_IDX_W-1:0] BIT_IDX_LAST = BIT_IDX_W'(UART_DATA_BITS - 1);

  uart_state_e                 state_q, state_d;
  logic [UART_DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [BIT_IDX_W-1:0]        bit_idx_q, bit_idx_d;
  logic                        txd_d, busy_d, done_d;
  logic                        bit_end;
`ifdef UART_TX_PARITY_EN
  logic                        parity_q, parity_d;
`endif

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (state_q != ST_IDLE),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      TXD       <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      TXD       <= txd_d;
      busy      <= busy_d;
      done      <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Next state; outputs are derived from the next state so they register with it.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    txd_d     = 1'b1;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (wr_en) begin
          shreg_d   = data;
          bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^data;
`endif
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == BIT_IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
            shreg_d   = shreg_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);

    unique case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = parity_d;
`endif
      default:   txd_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 16 clocks per bit; honours UART_TX_PARITY_EN.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int C = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = int'(UART_FRAME_BITS_PAR);
`else
  localparam int NB = int'(UART_FRAME_BITS_NOPAR);
`endif
  localparam int FC = NB * C;

  logic       clk, rst_n, wr_en, TXD, busy, done;
  logic [7:0] data;

  int total = 0;
  int bad   = 0;

  logic tx_s   [0:1023];
  logic busy_s [0:1023];
  logic done_s [0:1023];

  uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .data (data),
    .wr_en(wr_en),
    .TXD  (TXD),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[3'(idx - 1)];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Pulse wr_en for one cycle; returns in cycle 1, the first start-bit cycle.
  task automatic write_byte(input logic [7:0] b);
    @(posedge clk); #1;
    data  = b;
    wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Record outputs at cycles 1..n; optionally raise wr_en with inj_d from cycle inj_at.
  task automatic capture(input int n, input int inj_at, input logic [7:0] inj_d);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      tx_s[c]   = TXD;
      busy_s[c] = busy;
      done_s[c] = done;
      wr_en     = 1'b0;
      if (c == inj_at) begin
        data  = inj_d;
        wr_en = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++;
    if ({TXD, busy, done} !== 3'b100) begin
      bad++; $display("FAIL reset_held: txd/busy/done=%b%b%b want 100", TXD, busy, done);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({TXD, busy, done} !== 3'b100) begin
      bad++; $display("FAIL reset_released: txd/busy/done=%b%b%b want 100", TXD, busy, done);
    end
  endtask

  task automatic test_frame_55;
    write_byte(8'h55);
    capture(FC + 2, -1, 8'h00);
    for (int c = 1; c <= FC; c++) begin
      total++;
      if ({tx_s[c], busy_s[c], done_s[c]} !== {frame_bit(8'h55, (c - 1) / C), 2'b10}) begin
        bad++; $display("FAIL frame55 cycle %0d: txd/busy/done=%b%b%b want %b10",
                        c, tx_s[c], busy_s[c], done_s[c], frame_bit(8'h55, (c - 1) / C));
      end
    end
    total++;
    if ({tx_s[FC+1], busy_s[FC+1], done_s[FC+1]} !== 3'b101) begin
      bad++; $display("FAIL frame55_done cycle %0d: txd/busy/done=%b%b%b want 101",
                      FC + 1, tx_s[FC+1], busy_s[FC+1], done_s[FC+1]);
    end
    total++;
    if ({tx_s[FC+2], busy_s[FC+2], done_s[FC+2]} !== 3'b100) begin
      bad++; $display("FAIL frame55_after: txd/busy/done=%b%b%b want 100",
                      tx_s[FC+2], busy_s[FC+2], done_s[FC+2]);
    end
  endtask

  task automatic test_drop_busy;
    write_byte(8'hA5);
    capture(FC + 1 + 2 * C, 49, 8'hFF);
    for (int c = 1; c <= FC; c++) begin
      total++;
      if ({tx_s[c], busy_s[c], done_s[c]} !== {frame_bit(8'hA5, (c - 1) / C), 2'b10}) begin
        bad++; $display("FAIL dropA5 cycle %0d: txd/busy/done=%b%b%b want %b10",
                        c, tx_s[c], busy_s[c], done_s[c], frame_bit(8'hA5, (c - 1) / C));
      end
    end
    total++;
    if (done_s[FC+1] !== 1'b1) begin
      bad++; $display("FAIL dropA5_done: done=%b want 1", done_s[FC+1]);
    end
    for (int c = FC + 2; c <= FC + 1 + 2 * C; c++) begin
      total++;
      if ({tx_s[c], busy_s[c], done_s[c]} !== 3'b100) begin
        bad++; $display("FAIL drop_no_second cycle %0d: txd/busy/done=%b%b%b want 100",
                        c, tx_s[c], busy_s[c], done_s[c]);
      end
    end
  endtask

  task automatic test_back_to_back;
    write_byte(8'h3C);
    capture(2 * FC + 3, FC + 1, 8'hC3);
    for (int c = 1; c <= FC; c++) begin
      total++;
      if ({tx_s[c], busy_s[c]} !== {frame_bit(8'h3C, (c - 1) / C), 1'b1}) begin
        bad++; $display("FAIL b2b_first cycle %0d: txd/busy=%b%b want %b1",
                        c, tx_s[c], busy_s[c], frame_bit(8'h3C, (c - 1) / C));
      end
    end
    total++;
    if ({tx_s[FC+1], busy_s[FC+1], done_s[FC+1]} !== 3'b101) begin
      bad++; $display("FAIL b2b_done: txd/busy/done=%b%b%b want 101",
                      tx_s[FC+1], busy_s[FC+1], done_s[FC+1]);
    end
    for (int j = 1; j <= FC; j++) begin
      total++;
      if ({tx_s[FC+1+j], busy_s[FC+1+j], done_s[FC+1+j]} !==
          {frame_bit(8'hC3, (j - 1) / C), 2'b10}) begin
        bad++; $display("FAIL b2b_second cycle %0d: txd/busy/done=%b%b%b want %b10",
                        j, tx_s[FC+1+j], busy_s[FC+1+j], done_s[FC+1+j],
                        frame_bit(8'hC3, (j - 1) / C));
      end
    end
    total++;
    if ({busy_s[2*FC+2], done_s[2*FC+2]} !== 2'b01) begin
      bad++; $display("FAIL b2b_second_done: busy/done=%b%b want 01",
                      busy_s[2*FC+2], done_s[2*FC+2]);
    end
  endtask

  task automatic test_reset_mid_frame;
    write_byte(8'h00);
    capture(4 * C + 5, -1, 8'h00);
    total++;
    if (tx_s[4*C+5] !== 1'b0) begin
      bad++; $display("FAIL midrst_pre: txd=%b want 0", tx_s[4*C+5]);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({TXD, busy, done} !== 3'b100) begin
      bad++; $display("FAIL midrst_async: txd/busy/done=%b%b%b want 100", TXD, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    capture(3, -1, 8'h00);
    total++;
    if ({tx_s[3], busy_s[3], done_s[3]} !== 3'b100) begin
      bad++; $display("FAIL midrst_idle: txd/busy/done=%b%b%b want 100",
                      tx_s[3], busy_s[3], done_s[3]);
    end
    write_byte(8'h81);
    capture(FC + 1, -1, 8'h00);
    for (int c = 1; c <= FC; c++) begin
      total++;
      if ({tx_s[c], busy_s[c], done_s[c]} !== {frame_bit(8'h81, (c - 1) / C), 2'b10}) begin
        bad++; $display("FAIL midrst_81 cycle %0d: txd/busy/done=%b%b%b want %b10",
                        c, tx_s[c], busy_s[c], done_s[c], frame_bit(8'h81, (c - 1) / C));
      end
    end
    total++;
    if ({busy_s[FC+1], done_s[FC+1]} !== 2'b01) begin
      bad++; $display("FAIL midrst_81_done: busy/done=%b%b want 01", busy_s[FC+1], done_s[FC+1]);
    end
  endtask

  // Decode each frame at mid-bit like a receiver would.
  task automatic test_loopback;
    logic [7:0] vec [3];
    logic [7:0] rx;
    int pulses;
    vec[0] = 8'h00; vec[1] = 8'hFF; vec[2] = 8'h5A;
    for (int v = 0; v < 3; v++) begin
      write_byte(vec[v]);
      capture(FC + 2, -1, 8'h00);
      for (int k = 0; k < 8; k++) rx[k] = tx_s[1 + (k + 1) * C + C / 2];
      total++;
      if (rx !== vec[v]) begin
        bad++; $display("FAIL loopback_byte %0d: got %h want %h", v, rx, vec[v]);
      end
      total++;
      if ({tx_s[1 + C / 2], tx_s[1 + (NB - 1) * C + C / 2]} !== 2'b01) begin
        bad++; $display("FAIL loopback_framing %0d: start/stop=%b%b want 01",
                        v, tx_s[1 + C / 2], tx_s[1 + (NB - 1) * C + C / 2]);
      end
      pulses = 0;
      for (int c = 1; c <= FC + 2; c++) if (done_s[c] === 1'b1) pulses++;
      total++;
      if (pulses != 1) begin
        bad++; $display("FAIL loopback_done_count %0d: got %0d want 1", v, pulses);
      end
    end
  endtask

  task automatic test_byte_07;
    write_byte(8'h07);
    capture(FC + 1, -1, 8'h00);
    total++;
`ifdef UART_TX_PARITY_EN
    if ({tx_s[9*C+1], tx_s[10*C+1]} !== 2'b11) begin
      bad++; $display("FAIL parity07: parity/stop=%b%b want 11", tx_s[9*C+1], tx_s[10*C+1]);
    end
`else
    if ({tx_s[8*C+1], tx_s[9*C+1]} !== 2'b01) begin
      bad++; $display("FAIL nopar07: bit7/stop=%b%b want 01", tx_s[8*C+1], tx_s[9*C+1]);
    end
`endif
    total++;
    if ({busy_s[FC], done_s[FC], busy_s[FC+1], done_s[FC+1]} !== 4'b1001) begin
      bad++; $display("FAIL len07: busy/done at end=%b%b then %b%b want 10 then 01",
                      busy_s[FC], done_s[FC], busy_s[FC+1], done_s[FC+1]);
    end
  endtask

  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    wr_en = 1'b0;
    data  = 8'h00;
    test_reset;
    test_frame_55;
    test_drop_busy;
    test_back_to_back;
    test_reset_mid_frame;
    test_loopback;
    test_byte_07;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
